// File: rtl/lsu.sv
// Load-store unit: byte-addressable data memory plus LED/HEX/switch I/O window.
// Latency: loads are combinational (same cycle as addr); stores commit at the next clk edge.
// Backpressure: none; every access completes in one cycle, bad accesses are dropped.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   addr, funct3        byte address and access size/extension (B/H/W/BU/HU)
//   st_data, st_en      store data (rs2) and store request
//   ld_data, misaligned extended load data and alignment error flag (combinational)
//   io_sw               raw switch inputs, synchronised internally
//   io_ledr/ledg/hex    memory-mapped output registers
module lsu #(
   parameter int unsigned DMEM_WORDS = 2048,
   parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
   parameter logic [31:0] IO_BASE    = 32'h0000_7000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   input  logic        st_en,
   input  logic [2:0]  funct3,
   output logic [31:0] ld_data,
   output logic        misaligned,
   input  logic [31:0] io_sw,
   output logic [31:0] io_ledr,
   output logic [31:0] io_ledg,
   output logic [31:0] io_hex
);

   localparam int unsigned AW         = $clog2(DMEM_WORDS);
   localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
   localparam logic [31:0] LEDR_A     = IO_BASE;
   localparam logic [31:0] LEDG_A     = IO_BASE + 32'h10;
   localparam logic [31:0] HEX_A      = IO_BASE + 32'h20;
   localparam logic [31:0] SW_A       = IO_BASE + 32'h800;

   logic [31:0] mem [DMEM_WORDS];

   logic [31:0] ledr_q, ledr_d;
   logic [31:0] ledg_q, ledg_d;
   logic [31:0] hex_q,  hex_d;
   logic [31:0] sw_meta_q, sw_sync_q;

   logic [31:0] dmem_off;
   logic [AW-1:0] idx;
   logic        dmem_hit, ledr_hit, ledg_hit, hex_hit, sw_hit;
   logic        f3_valid, wr_ok;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rd_word, rd_shift;

   // Replace the byte lanes selected by be, keep the rest.
   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  lanes);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++)
         if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   // ---------------- address decode ----------------
   always_comb begin
      dmem_off = addr - DMEM_BASE;
      // Both bounds checked so addresses below the base (which wrap in
      // dmem_off) and at/after the end are unmapped.
      dmem_hit = (addr >= DMEM_BASE) && (dmem_off < DMEM_BYTES);
      idx      = dmem_off[AW+1:2];
      ledr_hit = (addr[31:2] == LEDR_A[31:2]);
      ledg_hit = (addr[31:2] == LEDG_A[31:2]);
      hex_hit  = (addr[31:2] == HEX_A[31:2]);
      sw_hit   = (addr[31:2] == SW_A[31:2]);
   end

   // ---------------- size / alignment ----------------
   always_comb begin
      f3_valid   = 1'b0;
      misaligned = 1'b0;
      case (funct3)
         3'b000, 3'b100: begin f3_valid = 1'b1; misaligned = 1'b0; end
         3'b001, 3'b101: begin f3_valid = 1'b1; misaligned = addr[0]; end
         3'b010:         begin f3_valid = 1'b1; misaligned = (addr[1:0] != 2'b00); end
         default:        begin f3_valid = 1'b0; misaligned = (addr[1:0] != 2'b00); end
      endcase
   end

   assign wr_ok = st_en && f3_valid && !misaligned;

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr[1:0];
            wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{st_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = st_data;
         end
      endcase
   end

   // ---------------- load path ----------------
   always_comb begin
      rd_word = 32'h0;
      if (dmem_hit)      rd_word = mem[idx];
      else if (ledr_hit) rd_word = ledr_q;
      else if (ledg_hit) rd_word = ledg_q;
      else if (hex_hit)  rd_word = hex_q;
      else if (sw_hit)   rd_word = sw_sync_q;

      rd_shift = rd_word >> {addr[1:0], 3'b000};

      ld_data = 32'h0;
      if (!misaligned) begin
         case (funct3)
            3'b000:  ld_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'h0, rd_shift[7:0]};
            3'b101:  ld_data = {16'h0, rd_shift[15:0]};
            default: ld_data = 32'h0;
         endcase
      end
   end

   // ---------------- data memory (not reset) ----------------
   always_ff @(posedge clk) begin
      if (rst_n && wr_ok && dmem_hit) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   // ---------------- I/O registers ----------------
   always_comb begin
      ledr_d = (wr_ok && ledr_hit) ? merge(ledr_q, wdata, be) : ledr_q;
      ledg_d = (wr_ok && ledg_hit) ? merge(ledg_q, wdata, be) : ledg_q;
      hex_d  = (wr_ok && hex_hit)  ? merge(hex_q,  wdata, be) : hex_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ledr_q    <= 32'h0;
         ledg_q    <= 32'h0;
         hex_q     <= 32'h0;
         sw_meta_q <= 32'h0;
         sw_sync_q <= 32'h0;
      end else begin
         ledr_q    <= ledr_d;
         ledg_q    <= ledg_d;
         hex_q     <= hex_d;
         sw_meta_q <= io_sw;      // first flop may go metastable
         sw_sync_q <= sw_meta_q;
      end
   end

   assign io_ledr = ledr_q;
   assign io_ledg = ledg_q;
   assign io_hex  = hex_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: load results go through an expected-value queue.
// Latency: loads sampled on the falling edge of the cycle they are driven.
// Backpressure: not applicable.
module tb_lsu;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic        st_en;
   logic [2:0]  funct3;
   logic [31:0] ld_data;
   logic        misaligned;
   logic [31:0] io_sw;
   logic [31:0] io_ledr;
   logic [31:0] io_ledg;
   logic [31:0] io_hex;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                          F_BU = 3'b100, F_HU = 3'b101, F_X = 3'b011;

   lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .st_data    (st_data),
      .st_en      (st_en),
      .funct3     (funct3),
      .ld_data    (ld_data),
      .misaligned (misaligned),
      .io_sw      (io_sw),
      .io_ledr    (io_ledr),
      .io_ledg    (io_ledg),
      .io_hex     (io_hex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One store cycle: inputs held across one rising edge.
   task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
      addr    = a;
      funct3  = f3;
      st_data = d;
      st_en   = 1'b1;
      @(posedge clk);
      #1 st_en = 1'b0;
   endtask

   // One load cycle: expected value queued at drive time, compared on the falling edge.
   task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] exp);
      addr   = a;
      funct3 = f3;
      st_en  = 1'b0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge clk);
      chk(tag_q.pop_front(), ld_data, exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; addr = 32'h0; st_data = 32'h0; st_en = 1'b0;
      funct3 = F_W; io_sw = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ledr", io_ledr, 32'h0);
      chk("rst_ledg", io_ledg, 32'h0);
      chk("rst_hex",  io_hex,  32'h0);
      @(posedge clk); #1;

      // Reset clears I/O registers and wins over a simultaneous store.
      st(32'h7000, F_W, 32'h1234_5678);
      st(32'h7010, F_W, 32'h0BAD_F00D);
      st(32'h7020, F_W, 32'h0F0F_0F0F);
      chk("pre_ledr", io_ledr, 32'h1234_5678);
      chk("pre_ledg", io_ledg, 32'h0BAD_F00D);
      rst_n = 1'b0;
      st(32'h7000, F_W, 32'h0000_0077);
      rst_n = 1'b1;
      chk("rst2_ledr", io_ledr, 32'h0);
      chk("rst2_ledg", io_ledg, 32'h0);
      chk("rst2_hex",  io_hex,  32'h0);

      // Sign/zero extension across lanes.
      st(32'h2000, F_W, 32'hDEAD_BEEF);
      ld("lb_2003",  32'h2003, F_B,  32'hFFFF_FFDE);
      ld("lbu_2003", 32'h2003, F_BU, 32'h0000_00DE);
      ld("lh_2000",  32'h2000, F_H,  32'hFFFF_BEEF);
      ld("lhu_2002", 32'h2002, F_HU, 32'h0000_DEAD);
      ld("lb_2000",  32'h2000, F_B,  32'hFFFF_FFEF);
      ld("lbu_2001", 32'h2001, F_BU, 32'h0000_00BE);
      ld("lh_2002",  32'h2002, F_H,  32'hFFFF_DEAD);

      // Partial stores keep untouched lanes.
      st(32'h2001, F_B, 32'hFFFF_FF55);
      ld("sb_merge", 32'h2000, F_W, 32'hDEAD_55EF);
      st(32'h2002, F_H, 32'hAAAA_1234);
      ld("sh_merge", 32'h2000, F_W, 32'h1234_55EF);

      // Misaligned store is dropped and flagged.
      addr = 32'h2002; funct3 = F_W; st_data = 32'h9999_9999; st_en = 1'b1;
      @(negedge clk);
      chk("mis_flag", {31'b0, misaligned}, 32'h1);
      chk("mis_ld",   ld_data, 32'h0);
      @(posedge clk); #1 st_en = 1'b0;
      ld("mis_nowr", 32'h2000, F_W, 32'h1234_55EF);
      ld("lh_odd",   32'h2001, F_H, 32'h0);
      addr = 32'h2002; funct3 = F_H;
      @(negedge clk);
      chk("h_aligned_flag", {31'b0, misaligned}, 32'h0);
      @(posedge clk); #1;

      // Reserved funct3: load 0, store dropped.
      st(32'h2000, F_X, 32'h0);
      ld("f3x_ld",   32'h2000, F_X, 32'h0);
      ld("f3x_nowr", 32'h2000, F_W, 32'h1234_55EF);

      // Store and load to same word in one cycle: old value first.
      addr = 32'h2000; funct3 = F_W; st_data = 32'hA1B2_C3D4; st_en = 1'b1;
      exp_q.push_back(32'h1234_55EF); tag_q.push_back("rdw_old");
      @(negedge clk);
      chk(tag_q.pop_front(), ld_data, exp_q.pop_front());
      @(posedge clk); #1 st_en = 1'b0;
      ld("rdw_new", 32'h2000, F_W, 32'hA1B2_C3D4);

      // DMEM boundaries.
      st(32'h3FFC, F_W, 32'hCAFE_F00D);
      ld("last_w",   32'h3FFC, F_W,  32'hCAFE_F00D);
      ld("last_b",   32'h3FFF, F_BU, 32'h0000_00CA);
      st(32'h4000, F_W, 32'h5555_5555);
      ld("past_end", 32'h4000, F_W,  32'h0);
      ld("no_wrap",  32'h2000, F_W,  32'hA1B2_C3D4);
      ld("below",    32'h1FFC, F_W,  32'h0);

      // LED / HEX lanes.
      st(32'h7000, F_W, 32'h0000_00FF);
      chk("ledr_ff", io_ledr, 32'h0000_00FF);
      ld("ledr_rd", 32'h7000, F_W, 32'h0000_00FF);
      st(32'h7020, F_W, 32'h1122_3344);
      st(32'h7021, F_B, 32'h0000_003F);
      chk("hex_byte", io_hex, 32'h1122_3F44);
      ld("hex_rdb", 32'h7021, F_BU, 32'h0000_003F);
      st(32'h7012, F_H, 32'h0000_BEEF);
      chk("ledg_half", io_ledg, 32'hBEEF_0000);
      st(32'h7004, F_W, 32'hFFFF_FFFF);
      chk("unmapped_st", io_ledr, 32'h0000_00FF);
      ld("unmapped_ld", 32'h7004, F_W, 32'h0);

      // Switch synchroniser: two edges of delay.
      io_sw = 32'h0000_00A5;
      ld("sw_n0", 32'h7800, F_W, 32'h0);
      ld("sw_n1", 32'h7800, F_W, 32'h0);
      ld("sw_n2", 32'h7800, F_W, 32'h0000_00A5);
      st(32'h7800, F_W, 32'h1234_5678);
      ld("sw_ro", 32'h7800, F_W, 32'h0000_00A5);
      chk("sw_st_ledr", io_ledr, 32'h0000_00FF);

      if (exp_q.size() != 0) chk("sb_drain", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
